// File: rtl/core_job_sequencer.sv
// Single-job instruction sequencer: weight fetch, kernel load, activation fetch,
// execute and OFIFO drain. `define SEQ_PERF_CNT_EN adds the perf_cycles counter.
module core_job_sequencer #(
    parameter int ROW    = 8,
    parameter int GAP    = 10,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic [ADDR_W:0]   n_x,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic              busy,
    output logic              done,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
`endif
    output logic              err
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] NMAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] ROW_C  = CW'(ROW);
    localparam logic [CW-1:0] ROW_M1 = CW'(ROW - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);
    localparam logic [33:0]   IDLE_INST = 34'h1800C0000;

    typedef enum logic [2:0] {
        S_IDLE, S_WREAD, S_KLOAD, S_KGAP,
        S_XREAD, S_EXEC, S_PSUMW, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] nx_q, nx_d;
    logic [ADDR_W-1:0] wb_q, wb_d, xb_q, xb_d, pb_q, pb_d;
    logic [33:0] inst_q, inst_d;
    logic busy_q, done_q, err_q, err_d;
    logic accept, rd_go, wr_go;
    logic xcen, pcen, pwen, l0wr, l0rd, exe, ld;
    logic [ADDR_W-1:0] xa, pa;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        wb_d  = wb_q;
        xb_d  = xb_q;
        pb_d  = pb_q;
        nx_d  = nx_q;
        err_d = err_q;
        if (accept) begin
            wb_d  = w_base;
            xb_d  = x_base;
            pb_d  = p_base;
            nx_d  = (n_x > NMAX) ? NMAX : n_x;
            err_d = (n_x > NMAX);
        end else if (start) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + ONE;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rd_go   = 1'b0;
        wr_go   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = S_WREAD;
                    rd_d    = '0;
                    wr_d    = '0;
                end
            end
            S_WREAD: if (cnt_q == ROW_C) begin
                state_d = S_KLOAD;
                cnt_d   = '0;
            end
            S_KLOAD: if (cnt_q == ROW_M1) begin
                state_d = S_KGAP;
                cnt_d   = '0;
            end
            S_KGAP: if (cnt_q == GAP_M1) begin
                state_d = (nx_q == '0) ? S_DONE : S_XREAD;
                cnt_d   = '0;
            end
            S_XREAD: if (cnt_q == nx_q) begin
                state_d = S_EXEC;
                cnt_d   = '0;
            end
            S_EXEC: if (cnt_q == nx_q - ONE) begin
                state_d = S_PSUMW;
                cnt_d   = '0;
            end
            S_PSUMW: if (wr_q == nx_q) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Each OFIFO read is followed next cycle by its PSUM write.
        if (state_d == S_PSUMW) begin
            rd_go = ofifo_valid && (rd_q < nx_q);
            wr_go = inst_q[6];
            rd_d  = rd_q + CW'(rd_go);
            wr_d  = wr_q + CW'(wr_go);
        end
    end

    always_comb begin
        xcen = 1'b1;
        pcen = 1'b1;
        pwen = 1'b1;
        l0wr = 1'b0;
        l0rd = 1'b0;
        exe  = 1'b0;
        ld   = 1'b0;
        xa   = '0;
        pa   = '0;
        unique case (state_d)
            S_WREAD: begin
                if (cnt_d < ROW_C) begin
                    xcen = 1'b0;
                    xa   = wb_d + cnt_d[ADDR_W-1:0];
                end
                l0wr = (cnt_d != '0);
            end
            S_KLOAD: begin
                ld   = 1'b1;
                l0rd = 1'b1;
            end
            S_XREAD: begin
                if (cnt_d < nx_d) begin
                    xcen = 1'b0;
                    xa   = xb_d + cnt_d[ADDR_W-1:0];
                end
                l0wr = (cnt_d != '0);
            end
            S_EXEC: begin
                exe  = 1'b1;
                l0rd = 1'b1;
            end
            S_PSUMW: begin
                pcen = ~wr_go;
                pwen = ~wr_go;
                pa   = pb_d + wr_q[ADDR_W-1:0];
            end
            default: ;
        endcase
        inst_d = {1'b0, pcen, pwen, pa, xcen, 1'b1, xa,
                  rd_go, 2'b00, l0rd, l0wr, exe, ld};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            nx_q    <= '0;
            wb_q    <= '0;
            xb_q    <= '0;
            pb_q    <= '0;
            inst_q  <= IDLE_INST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            nx_q    <= nx_d;
            wb_q    <= wb_d;
            xb_q    <= xb_d;
            pb_q    <= pb_d;
            inst_q  <= inst_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            err_q   <= err_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 32'hFFFFFFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end
    assign perf_cycles = perf_q;
`endif

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: doc/core_job_sequencer.md
Name: core_job_sequencer

Overview:
- Single-job instruction sequencer for the weight-stationary core.
- Drives the core's 34-bit inst bus through these phases: weight fetch from xMem into L0, kernel load into the PE array, activation fetch, execute, and OFIFO drain into PSUM memory.
- Sits between the host/testbench job interface and the core; it replaces hand-written per-cycle instruction streams.

Parameters:
- ROW, 8, PE array rows; weight words fetched and kernel-load cycles.
- GAP, 10, idle cycles between kernel load and activation fetch; valid range 1..63.
- ADDR_W, 11, SRAM address width; xMem and PSUM are both 2048 deep.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- w_base  in  11  xMem base address of the ROW weight words.
- x_base  in  11  xMem base address of the activation words.
- p_base  in  11  PSUM base address for outputs.
- n_x  in  12  activation/output count; legal 0..2048.
- ofifo_valid  in  1  core OFIFO has a word ready.
- inst  out  34  registered instruction to the core.
- busy  out  1  high from the cycle after start until DONE, inclusive.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  sticky; set on start-while-busy or n_x>2048; cleared by the next accepted start.

Behaviour:
- inst field map:
  - [33] acc (always 0).
  - [32] psum CEN, [31] psum WEN, [30:20] psum A.
  - [19] xMem CEN, [18] xMem WEN, [17:7] xMem A.
  - [6] ofifo_rd, [5:4] ififo wr/rd (always 0), [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- Idle inst value: CENs=1, WENs=1, all other bits 0, i.e. 34'h1800C0000.
- Reset (async, active-low): state=IDLE, inst=idle value, busy=0, done=0, err=0. Reset mid-job aborts immediately with no partial write.
- Registered outputs: inst in a cycle reflects the current state and counters.
- States and durations:
  - IDLE: start=1 latches bases and n_x (n_x saturated to 2048) and moves to WREAD.
  - WREAD, ROW+1 cycles: cycles 0..ROW-1 drive xMem CEN=0, WEN=1, A=w_base+i. Cycles 1..ROW drive l0_wr=1, matching the one-cycle SRAM read latency.
  - KLOAD, ROW cycles: load=1, l0_rd=1.
  - KGAP, GAP cycles: idle inst. If n_x==0, go straight to DONE.
  - XREAD, n_x+1 cycles: same pattern as WREAD with A=x_base+i.
  - EXEC, n_x cycles: execute=1, l0_rd=1.
  - PSUMW: each cycle ofifo_valid=1 and rd_cnt<n_x, assert ofifo_rd. The cycle after each ofifo_rd, drive psum CEN=0, WEN=0, A=p_base+j and increment j. Exit when j==n_x; the final write is the last PSUMW cycle.
  - DONE, 1 cycle: done=1, idle inst, then IDLE.
- Addresses wrap modulo 2048 (base+i truncated to 11 bits).
- ofifo_valid low stalls PSUMW indefinitely; the pending write still issues.
- start while busy is ignored and sets err. start and DONE in the same cycle: start is ignored, since start is sampled only in IDLE.
- xMem and PSUM never have CEN=0 in the same cycle except PSUMW (PSUM only).

Optional Feature:
- SEQ_PERF_CNT_EN.
- Defined: adds output perf_cycles[31:0], which counts busy cycles of the current job and holds the value of the last job after DONE. Saturates at 32'hFFFFFFFF. Resets to 0; cleared on accepted start.
- Undefined: the port and counter are absent.

Test Plan:
- Reset: reset=0 with random inputs -> inst=34'h1800C0000, busy=0, done=0, err=0.
- Nominal job: ROW=8, GAP=10, n_x=4, w_base=0, x_base=16, p_base=100, ofifo_valid=1, start at cycle 0.
  - xMem A 0..7 in cycles 1..8; load in cycles 10..17; xMem A 16..19 in cycles 28..31; execute in cycles 33..36.
  - PSUM writes A 100..103; done at cycle 42.
- Zero-length job: n_x=0 -> WREAD, KLOAD, KGAP only; done at cycle 28; no xMem activation read, no PSUM write.
- Wrap: x_base=2046, n_x=4 -> xMem A 2046, 2047, 0, 1; p_base=2047 -> PSUM A 2047, 0, 1, 2.
- Stall: ofifo_valid toggled 1,0,0,1,... -> exactly n_x ofifo_rd pulses and n_x PSUM writes, each one cycle after its read; done only after the last write.
- Errors: start during EXEC -> job unaffected, err=1. n_x=3000 -> 2048 outputs, err=1. A later clean start clears err.
